fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem requests, fills the IF/ID register,
// parks one word in a hold buffer when decode stalls, and drains an
// outstanding request after a redirect so stale data never reaches decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] req_addr;
  logic [31:0] hold_instr;
  logic [63:0] hold_pc;

  logic [63:0] pc_plus4;
  logic [63:0] redirect_pc;
  logic        ifid_free;
  logic        ifid_consume;

  assign pc_plus4     = pc + 64'd4;
  assign redirect_pc  = branch_target & ~64'h3;
  assign ifid_free    = !id_valid || !stall;
  assign ifid_consume = id_valid && !stall;

  assign imem_req  = (state != HOLD);
  assign imem_addr = req_addr;

  // Fetch FSM, IF/ID register and hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
      id_instr   <= '0;
      id_pc      <= '0;
      id_valid   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            id_valid <= 1'b0;
            pc       <= redirect_pc;
            if (imem_ack) begin
              req_addr <= redirect_pc;
            end else begin
              // request still in flight at the old address; let it complete
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (ifid_free) begin
              id_instr <= imem_rdata;
              id_pc    <= req_addr;
              id_valid <= 1'b1;
              req_addr <= pc_plus4;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= req_addr;
              state      <= HOLD;
            end
          end else if (ifid_consume) begin
            id_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            id_valid <= 1'b0;
            pc       <= redirect_pc;
            req_addr <= redirect_pc;
            state    <= FETCH;
          end else if (!stall) begin
            id_instr <= hold_instr;
            id_pc    <= hold_pc;
            id_valid <= 1'b1;
            req_addr <= pc;
            state    <= FETCH;
          end
        end

        DRAIN: begin
          // a redirect here only retargets pc; the pending ack is still discarded
          if (branch_taken) begin
            id_valid <= 1'b0;
            pc       <= redirect_pc;
          end else if (imem_ack) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
